// File: rtl/hcordic_fix_pkg.sv
// Shared float-field constants and operand classes for the CORDIC fixed-point path.
package hcordic_fix_pkg;

   localparam int EXP_BIAS      = 127;
   localparam int MANT_W        = 23;
   localparam int EXP_MAX       = 255;
   localparam int FIX_FRAC_BITS = 28;

   typedef enum logic [1:0] {
      CLS_NORM,
      CLS_ZERO,
      CLS_INF,
      CLS_NAN
   } fp_cls_t;

endpackage

// File: rtl/fixconv_align.sv
// Bidirectional mantissa aligner: overflow detect on left shifts,
// guard/sticky capture on right shifts (PREPROCESS_FIXCONV_ROUND_NEAREST_EN).
module fixconv_align #(
   parameter int WIDTH = 32
) (
   input  logic              [23:0]      m24,
   input  logic signed       [9:0]       sh,
   output logic              [WIDTH-1:0] mag,
   output logic                          ovf
`ifdef PREPROCESS_FIXCONV_ROUND_NEAREST_EN
   ,
   output logic                          guard,
   output logic                          sticky
`endif
);

   localparam int FW = WIDTH + 24;

   logic [FW-1:0] field;
   logic [9:0]    n;
   logic          huge;
`ifdef PREPROCESS_FIXCONV_ROUND_NEAREST_EN
   logic [48:0]   t;
`endif

   always_comb begin
      field = '0;
      n     = 10'(-sh);
      huge  = 1'b0;
`ifdef PREPROCESS_FIXCONV_ROUND_NEAREST_EN
      t      = '0;
      guard  = 1'b0;
      sticky = 1'b0;
`endif
      if (!sh[9]) begin
         // Beyond WIDTH the leading one is certainly out of range.
         if ($unsigned(sh) > 10'(WIDTH))
            huge = 1'b1;
         else
            field = FW'(m24) << $unsigned(sh);
      end else if (n >= 10'd26) begin
`ifdef PREPROCESS_FIXCONV_ROUND_NEAREST_EN
         sticky = 1'b1;
`endif
      end else begin
`ifdef PREPROCESS_FIXCONV_ROUND_NEAREST_EN
         t      = {m24, 25'b0} >> n;
         field  = FW'(t[48:25]);
         guard  = t[24];
         sticky = |t[23:0];
`else
         field  = FW'(m24 >> n);
`endif
      end
      mag = field[WIDTH-1:0];
      ovf = huge | (|field[FW-1:WIDTH]);
   end

endmodule

// File: rtl/preprocess_fixconv.sv
// 3-stage IEEE-754 single to signed fixed-point converter with sideband delay.
// Build option: PREPROCESS_FIXCONV_ROUND_NEAREST_EN selects round-to-nearest-even.
module preprocess_fixconv
   import hcordic_fix_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int FRAC_BITS = FIX_FRAC_BITS
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [31:0]      FinalSum,
   input  logic             Done,
   input  logic [31:0]      z_postprocess,
   input  logic [3:0]       Opcode_out,
   input  logic [7:0]       InsTagOut,
   output logic [WIDTH-1:0] fixed_out,
   output logic             valid_fix,
   output logic [31:0]      z_fix,
   output logic [3:0]       Opcode_fix,
   output logic [7:0]       InsTagFix,
   output logic             sat_flag,
   output logic             nan_flag
);

   localparam logic signed [9:0] SH_OFF  = 10'(FRAC_BITS - EXP_BIAS - MANT_W);
   localparam logic [WIDTH-1:0]  POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0]  NEG_MAX = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH:0]    LIM     = {1'b0, NEG_MAX};

   // stage 1
   fp_cls_t            cls_c;
   logic signed [9:0]  sh_c;
   logic               s1_valid, s1_s;
   fp_cls_t            s1_cls;
   logic [23:0]        s1_m24;
   logic signed [9:0]  s1_sh;
   logic [31:0]        s1_z;
   logic [3:0]         s1_op;
   logic [7:0]         s1_tag;

   always_comb begin
      cls_c = CLS_NORM;
      sh_c  = $signed({2'b00, FinalSum[30:23]}) + SH_OFF;
      if (FinalSum[30:23] == 8'd0)
         cls_c = CLS_ZERO;
      else if (FinalSum[30:23] == 8'(EXP_MAX))
         cls_c = (FinalSum[22:0] == '0) ? CLS_INF : CLS_NAN;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_s     <= 1'b0;
         s1_cls   <= CLS_NORM;
         s1_m24   <= '0;
         s1_sh    <= '0;
         s1_z     <= '0;
         s1_op    <= '0;
         s1_tag   <= '0;
      end else begin
         s1_valid <= Done;
         s1_s     <= FinalSum[31];
         s1_cls   <= cls_c;
         s1_m24   <= {1'b1, FinalSum[22:0]};
         s1_sh    <= sh_c;
         s1_z     <= z_postprocess;
         s1_op    <= Opcode_out;
         s1_tag   <= InsTagOut;
      end
   end

   // stage 2
   logic [WIDTH-1:0] mag_c;
   logic             ovf_c;
   logic             s2_valid, s2_s, s2_ovf;
   fp_cls_t          s2_cls;
   logic [WIDTH-1:0] s2_mag;
   logic [31:0]      s2_z;
   logic [3:0]       s2_op;
   logic [7:0]       s2_tag;
`ifdef PREPROCESS_FIXCONV_ROUND_NEAREST_EN
   logic             guard_c, sticky_c, s2_guard, s2_sticky;
`endif

   fixconv_align #(.WIDTH(WIDTH)) u_align (
      .m24    (s1_m24),
      .sh     (s1_sh),
      .mag    (mag_c),
      .ovf    (ovf_c)
`ifdef PREPROCESS_FIXCONV_ROUND_NEAREST_EN
      ,
      .guard  (guard_c),
      .sticky (sticky_c)
`endif
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         s2_valid <= 1'b0;
         s2_s     <= 1'b0;
         s2_ovf   <= 1'b0;
         s2_cls   <= CLS_NORM;
         s2_mag   <= '0;
         s2_z     <= '0;
         s2_op    <= '0;
         s2_tag   <= '0;
      end else begin
         s2_valid <= s1_valid;
         s2_s     <= s1_s;
         s2_ovf   <= ovf_c;
         s2_cls   <= s1_cls;
         s2_mag   <= mag_c;
         s2_z     <= s1_z;
         s2_op    <= s1_op;
         s2_tag   <= s1_tag;
      end
   end

`ifdef PREPROCESS_FIXCONV_ROUND_NEAREST_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         s2_guard  <= 1'b0;
         s2_sticky <= 1'b0;
      end else begin
         s2_guard  <= guard_c;
         s2_sticky <= sticky_c;
      end
   end
`endif

   // stage 3
   logic [WIDTH:0]   rnd;
   logic             too_big;
   logic [WIDTH-1:0] res_fx;
   logic             res_sat, res_nan;

   always_comb begin
`ifdef PREPROCESS_FIXCONV_ROUND_NEAREST_EN
      rnd = {1'b0, s2_mag}
          + (WIDTH+1)'(s2_guard & (s2_sticky | s2_mag[0]));
`else
      rnd = {1'b0, s2_mag};
`endif
      // -2^(WIDTH-1) is the only magnitude that fits on one side only
      too_big = s2_ovf || (rnd > LIM) || ((rnd == LIM) && !s2_s);
      res_fx  = '0;
      res_sat = 1'b0;
      res_nan = 1'b0;
      unique case (s2_cls)
         CLS_NAN:  res_nan = 1'b1;
         CLS_ZERO: res_fx  = '0;
         CLS_INF: begin
            res_sat = 1'b1;
            res_fx  = s2_s ? NEG_MAX : POS_MAX;
         end
         CLS_NORM: begin
            if (too_big) begin
               res_sat = 1'b1;
               res_fx  = s2_s ? NEG_MAX : POS_MAX;
            end else begin
               res_fx  = s2_s ? -rnd[WIDTH-1:0] : rnd[WIDTH-1:0];
            end
         end
         default: res_fx = '0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         valid_fix  <= 1'b0;
         fixed_out  <= '0;
         sat_flag   <= 1'b0;
         nan_flag   <= 1'b0;
         z_fix      <= '0;
         Opcode_fix <= '0;
         InsTagFix  <= '0;
      end else begin
         valid_fix  <= s2_valid;
         fixed_out  <= res_fx;
         sat_flag   <= s2_valid & res_sat;
         nan_flag   <= s2_valid & res_nan;
         z_fix      <= s2_z;
         Opcode_fix <= s2_op;
         InsTagFix  <= s2_tag;
      end
   end

endmodule

// File: tb/tb_preprocess_fixconv.sv
// Self-checking bench for preprocess_fixconv (WIDTH=32, FRAC_BITS=28).
module tb_preprocess_fixconv;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] FinalSum = '0;
   logic        Done = 1'b0;
   logic [31:0] z_postprocess = '0;
   logic [3:0]  Opcode_out = '0;
   logic [7:0]  InsTagOut = '0;
   logic [31:0] fixed_out;
   logic        valid_fix;
   logic [31:0] z_fix;
   logic [3:0]  Opcode_fix;
   logic [7:0]  InsTagFix;
   logic        sat_flag;
   logic        nan_flag;

   always #5 clock = ~clock;

   preprocess_fixconv #(.WIDTH(32), .FRAC_BITS(28)) dut (
      .clock         (clock),
      .reset         (reset),
      .FinalSum      (FinalSum),
      .Done          (Done),
      .z_postprocess (z_postprocess),
      .Opcode_out    (Opcode_out),
      .InsTagOut     (InsTagOut),
      .fixed_out     (fixed_out),
      .valid_fix     (valid_fix),
      .z_fix         (z_fix),
      .Opcode_fix    (Opcode_fix),
      .InsTagFix     (InsTagFix),
      .sat_flag      (sat_flag),
      .nan_flag      (nan_flag)
   );

   typedef struct {
      logic        done;
      logic [31:0] z;
      logic [3:0]  op;
      logic [7:0]  tag;
      logic [31:0] fx;
      logic        sat;
      logic        nan;
      int          id;
   } rec_t;

   typedef struct {
      logic [31:0] f;
      logic [31:0] fx;
      logic        sat;
      logic        nan;
   } vec_t;

   rec_t hist[$];
   vec_t tbl[$];
   int   n_chk = 0;
   int   n_pass = 0;

   // Exact value-level model: m24 * 2^(e-150+28), rounded, then clamped.
   function automatic void ref_conv(input logic [31:0] f,
                                    output logic [31:0] fx,
                                    output logic sat, output logic nan);
      int     e;
      int     p;
      real    mag, t, fr, lim;
      longint v;
      e   = int'(f[30:23]);
      fx  = '0;
      sat = 1'b0;
      nan = 1'b0;
      lim = 2147483648.0;
      if (e == 255 && f[22:0] != 0) begin
         nan = 1'b1;
      end else if (e == 255) begin
         sat = 1'b1;
         fx  = f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end else if (e != 0) begin
         mag = real'({1'b1, f[22:0]});
         p   = e - 150 + 28;
         for (int i = 0; i < p; i++) mag = mag * 2.0;
         for (int i = 0; i < -p; i++) mag = mag / 2.0;
         t  = $floor(mag);
         fr = mag - t;
`ifdef PREPROCESS_FIXCONV_ROUND_NEAREST_EN
         if (fr > 0.5 || (fr == 0.5 && (t / 2.0 - $floor(t / 2.0)) != 0.0))
            t = t + 1.0;
`endif
         if (!f[31] && t >= lim) begin
            sat = 1'b1;
            fx  = 32'h7FFF_FFFF;
         end else if (f[31] && t > lim) begin
            sat = 1'b1;
            fx  = 32'h8000_0000;
         end else begin
            v  = longint'(t);
            fx = f[31] ? 32'(-v) : 32'(v);
         end
      end
   endfunction

   function automatic logic [31:0] rand_f();
      logic [31:0] f;
      int          k;
      k = int'($urandom_range(0, 15));
      f = $urandom();
      case (k)
         0: f[30:23] = 8'hFF;
         1: begin f[30:23] = 8'hFF; f[22:0] = '0; end
         2: f[30:23] = 8'h00;
         default: f[30:23] = 8'($urandom_range(95, 135));
      endcase
      if (k == 0 && f[22:0] == 0) f[0] = 1'b1;
      return f;
   endfunction

   task automatic compare_out(input rec_t r);
      logic ok;
      ok = (valid_fix === r.done) && (z_fix === r.z)
         && (Opcode_fix === r.op) && (InsTagFix === r.tag);
      if (r.done)
         ok = ok && (fixed_out === r.fx) && (sat_flag === r.sat)
            && (nan_flag === r.nan);
      else
         ok = ok && (sat_flag === 1'b0) && (nan_flag === 1'b0);
      n_chk++;
      if (ok) n_pass++;
      else
         $display("FAIL op%0d: got v=%b fx=%h sat=%b nan=%b tag=%h opc=%h z=%h want v=%b fx=%h sat=%b nan=%b tag=%h opc=%h z=%h",
                  r.id, valid_fix, fixed_out, sat_flag, nan_flag, InsTagFix,
                  Opcode_fix, z_fix, r.done, r.fx, r.sat, r.nan, r.tag, r.op, r.z);
   endtask

   task automatic cyc(input logic d, input logic [31:0] f,
                      input logic [7:0] tag, input logic [3:0] op,
                      input logic [31:0] z, input logic [31:0] efx,
                      input logic esat, input logic enan, input int id);
      rec_t r;
      Done          = d;
      FinalSum      = f;
      InsTagOut     = tag;
      Opcode_out    = op;
      z_postprocess = z;
      r = '{done: d, z: z, op: op, tag: tag, fx: efx, sat: esat, nan: enan, id: id};
      hist.push_back(r);
      @(posedge clock);
      #1;
      if (hist.size() == 3) begin
         compare_out(hist.pop_front());
      end else begin
         n_chk++;
         if (valid_fix === 1'b0 && sat_flag === 1'b0 && nan_flag === 1'b0)
            n_pass++;
         else
            $display("FAIL flush: got v=%b sat=%b nan=%b want all 0",
                     valid_fix, sat_flag, nan_flag);
      end
   endtask

   task automatic cyc_model(input logic d, input logic [31:0] f,
                            input logic [7:0] tag, input int id);
      logic [31:0] efx;
      logic        es, en;
      ref_conv(f, efx, es, en);
      cyc(d, f, tag, 4'($urandom()), $urandom(), efx, es, en, id);
   endtask

   task automatic do_reset(input int ncyc);
      reset         = 1'b1;
      Done          = 1'b1;
      FinalSum      = 32'h3F80_0000;
      InsTagOut     = 8'hAA;
      Opcode_out    = 4'h5;
      z_postprocess = 32'h1234_5678;
      repeat (ncyc) @(posedge clock);
      #1;
      n_chk++;
      if (valid_fix === 1'b0 && fixed_out === '0 && sat_flag === 1'b0
          && nan_flag === 1'b0 && z_fix === '0 && Opcode_fix === '0
          && InsTagFix === '0)
         n_pass++;
      else
         $display("FAIL reset: got v=%b fx=%h sat=%b nan=%b z=%h opc=%h tag=%h want all 0",
                  valid_fix, fixed_out, sat_flag, nan_flag, z_fix, Opcode_fix, InsTagFix);
      reset = 1'b0;
      Done  = 1'b0;
      hist.delete();
   endtask

   initial begin
      tbl.push_back('{32'h3F80_0000, 32'h1000_0000, 1'b0, 1'b0});
      tbl.push_back('{32'hC020_0000, 32'hD800_0000, 1'b0, 1'b0});
      tbl.push_back('{32'h4100_0000, 32'h7FFF_FFFF, 1'b1, 1'b0});
      tbl.push_back('{32'hC100_0000, 32'h8000_0000, 1'b0, 1'b0});
      tbl.push_back('{32'h40FF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0});
      tbl.push_back('{32'hC0FF_FFFF, 32'h8000_0080, 1'b0, 1'b0});
      tbl.push_back('{32'h7FC0_0000, 32'h0000_0000, 1'b0, 1'b1});
      tbl.push_back('{32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0});
      tbl.push_back('{32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, 1'b0});
      tbl.push_back('{32'h8000_0001, 32'h0000_0000, 1'b0, 1'b0});
      tbl.push_back('{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0});
      tbl.push_back('{32'h30C0_0000, 32'h0000_0000, 1'b0, 1'b0});
      tbl.push_back('{32'h3040_0000, 32'h0000_0000, 1'b0, 1'b0});
      tbl.push_back('{32'h3100_0000, 32'h0000_0000, 1'b0, 1'b0});
`ifdef PREPROCESS_FIXCONV_ROUND_NEAREST_EN
      tbl.push_back('{32'h3140_0000, 32'h0000_0001, 1'b0, 1'b0});
      tbl.push_back('{32'h3120_0000, 32'h0000_0001, 1'b0, 1'b0});
      tbl.push_back('{32'h31C0_0000, 32'h0000_0002, 1'b0, 1'b0});
      tbl.push_back('{32'hB140_0000, 32'hFFFF_FFFF, 1'b0, 1'b0});
`else
      tbl.push_back('{32'h3140_0000, 32'h0000_0000, 1'b0, 1'b0});
      tbl.push_back('{32'h3120_0000, 32'h0000_0000, 1'b0, 1'b0});
      tbl.push_back('{32'h31C0_0000, 32'h0000_0001, 1'b0, 1'b0});
      tbl.push_back('{32'hB140_0000, 32'h0000_0000, 1'b0, 1'b0});
`endif

      do_reset(3);

      // Isolated first conversion pins the 3-clock latency.
      for (int i = 0; i < tbl.size(); i++) begin
         cyc(1'b1, tbl[i].f, 8'h11, 4'h3, 32'(i), tbl[i].fx,
             tbl[i].sat, tbl[i].nan, i);
         if (i == 0) begin
            cyc(1'b0, 32'h0, 8'h00, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 900);
            cyc(1'b0, 32'h0, 8'h00, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 901);
         end
      end

      for (int i = 0; i < 8; i++) cyc_model(1'b1, rand_f(), 8'(8'h40 + i), 100 + i);
      for (int i = 0; i < 2; i++) cyc_model(1'b0, rand_f(), 8'(8'h50 + i), 108 + i);
      for (int i = 0; i < 3; i++) cyc_model(1'b1, rand_f(), 8'(8'h60 + i), 110 + i);

      for (int i = 0; i < 400; i++)
         cyc_model(($urandom_range(0, 3) != 0), rand_f(), 8'($urandom()), 200 + i);

      cyc_model(1'b1, 32'h3F80_0000, 8'hA1, 700);
      cyc_model(1'b1, 32'hC020_0000, 8'hA2, 701);
      do_reset(1);
      cyc_model(1'b1, 32'h4040_0000, 8'hB1, 702);
      for (int i = 0; i < 4; i++) cyc_model(1'b0, rand_f(), 8'(i), 703 + i);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
